// File: rtl/ps2_rx_fifo.sv
// ps2_rx_fifo: PS/2 keyboard receiver with a scan-code FIFO.
//   Synchronises the PS/2 clock and data lines and decodes 11-bit frames
//   (start, 8 data bits LSB-first, odd parity, stop).
//   Accepted bytes go into a FIFO. Rejected frames (bad parity, bad stop bit
//   or a stalled partial frame) set sticky error flags.
// Optional feature macro: PS2_RX_ERR_CNT_EN
//   When defined, a saturating 8-bit count of rejected frames drives err_cnt.
//   When undefined, err_cnt is tied to zero.
module ps2_rx_fifo #(
    parameter int FIFO_DEPTH     = 8,
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 5000
) (
    input  logic                          clk,
    input  logic                          clrn,
    input  logic                          ps2_clk,
    input  logic                          ps2_data,
    input  logic                          nextdata_n,
    output logic [7:0]                    data,
    output logic                          ready,
    output logic [$clog2(FIFO_DEPTH):0]   level,
    output logic                          overflow,
    output logic                          parity_err,
    output logic                          frame_err,
    output logic                          timeout_err,
    output logic [7:0]                    err_cnt
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [LW-1:0] LVL_ONE  = LW'(1);
    localparam logic [LW-1:0] LVL_FULL = LW'(FIFO_DEPTH);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [TW-1:0] TMO_ONE  = TW'(1);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RECV = 1'b1
    } state_t;

    // ------------------------------------------------------------------
    // Line synchronisers and falling-edge detector
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] clk_sync_q;
    logic [SYNC_STAGES-1:0] dat_sync_q;
    logic                   clk_prev_q;
    logic                   fall_s;
    logic                   bit_s;

    // Resynchronise both PS/2 lines; lines idle high so reset to ones.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            clk_sync_q <= {SYNC_STAGES{1'b1}};
            dat_sync_q <= {SYNC_STAGES{1'b1}};
            clk_prev_q <= 1'b1;
        end else begin
            clk_sync_q <= {clk_sync_q[SYNC_STAGES-2:0], ps2_clk};
            dat_sync_q <= {dat_sync_q[SYNC_STAGES-2:0], ps2_data};
            clk_prev_q <= clk_sync_q[SYNC_STAGES-1];
        end
    end

    assign fall_s = clk_prev_q & ~clk_sync_q[SYNC_STAGES-1];
    assign bit_s  = dat_sync_q[SYNC_STAGES-1];

    // ------------------------------------------------------------------
    // Frame receiver FSM
    // ------------------------------------------------------------------
    state_t        state_q;
    logic [3:0]    bit_cnt_q;
    logic [8:0]    shift_q;     // [7:0] data LSB at bit 0, [8] parity
    logic [TW-1:0] tmo_cnt_q;
    logic          parity_err_q;
    logic          frame_err_q;
    logic          timeout_err_q;

    logic          par_ok_s;
    logic          stop_evt_s;
    logic          accept_s;
    logic          tmo_evt_s;

    // Odd parity: XOR over data and parity bit must be one.
    assign par_ok_s   = ^shift_q;
    // The edge after nine shifted bits carries the stop bit.
    assign stop_evt_s = (state_q == ST_RECV) && fall_s && (bit_cnt_q == 4'd9);
    assign accept_s   = stop_evt_s && bit_s && par_ok_s;
    assign tmo_evt_s  = (state_q == ST_RECV) && !fall_s && (tmo_cnt_q == TMO_LAST);

    // Frame decode: start detection, bit shifting, stop check and timeout abort.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state_q       <= ST_IDLE;
            bit_cnt_q     <= 4'd0;
            shift_q       <= 9'd0;
            tmo_cnt_q     <= {TW{1'b0}};
            parity_err_q  <= 1'b0;
            frame_err_q   <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    bit_cnt_q <= 4'd0;
                    tmo_cnt_q <= {TW{1'b0}};
                    if (fall_s && !bit_s) begin
                        state_q <= ST_RECV;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_RECV: begin
                    if (fall_s) begin
                        tmo_cnt_q <= {TW{1'b0}};
                        if (bit_cnt_q == 4'd9) begin
                            state_q   <= ST_IDLE;
                            bit_cnt_q <= 4'd0;
                            if (!bit_s) begin
                                frame_err_q <= 1'b1;
                            end
                            if (!par_ok_s) begin
                                parity_err_q <= 1'b1;
                            end
                        end else begin
                            shift_q   <= {bit_s, shift_q[8:1]};
                            bit_cnt_q <= bit_cnt_q + 4'd1;
                        end
                    end else if (tmo_evt_s) begin
                        state_q       <= ST_IDLE;
                        bit_cnt_q     <= 4'd0;
                        timeout_err_q <= 1'b1;
                    end else begin
                        tmo_cnt_q <= tmo_cnt_q + TMO_ONE;
                    end
                end
                default: begin
                    state_q   <= ST_IDLE;
                    bit_cnt_q <= 4'd0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Scan-code FIFO
    // ------------------------------------------------------------------
    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [LW-1:0] level_q;
    logic [LW-1:0] level_d;
    logic          ready_q;
    logic          overflow_q;

    logic          pop_s;
    logic          full_s;
    logic          wr_en_s;

    assign pop_s   = ready_q & ~nextdata_n;
    assign full_s  = (level_q == LVL_FULL);
    // A write into a full FIFO is only allowed when a pop frees a slot.
    assign wr_en_s = accept_s & (~full_s | pop_s);

    // Next occupancy from the write/pop combination.
    always_comb begin
        level_d = level_q;
        case ({wr_en_s, pop_s})
            2'b10:   level_d = level_q + LVL_ONE;
            2'b01:   level_d = level_q - LVL_ONE;
            default: level_d = level_q;
        endcase
    end

    // Pointer, occupancy, ready and overflow bookkeeping.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            wr_ptr_q   <= {AW{1'b0}};
            rd_ptr_q   <= {AW{1'b0}};
            level_q    <= {LW{1'b0}};
            ready_q    <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            if (wr_en_s) begin
                wr_ptr_q <= wr_ptr_q + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_q <= rd_ptr_q + PTR_ONE;
            end
            if (accept_s && full_s && !pop_s) begin
                overflow_q <= 1'b1;
            end
            level_q <= level_d;
            ready_q <= (level_d != {LW{1'b0}});
        end
    end

    // Storage array; contents intentionally survive reset.
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            mem_q[wr_ptr_q] <= shift_q[7:0];
        end
    end

    assign data        = mem_q[rd_ptr_q];
    assign ready       = ready_q;
    assign level       = level_q;
    assign overflow    = overflow_q;
    assign parity_err  = parity_err_q;
    assign frame_err   = frame_err_q;
    assign timeout_err = timeout_err_q;

    // ------------------------------------------------------------------
    // Optional rejected-frame counter
    // ------------------------------------------------------------------
`ifdef PS2_RX_ERR_CNT_EN
    logic [7:0] err_cnt_q;
    logic       reject_s;

    assign reject_s = (stop_evt_s && !accept_s) || tmo_evt_s;

    // Saturating count of frames rejected for parity, stop or timeout.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            err_cnt_q <= 8'd0;
        end else if (reject_s && (err_cnt_q != 8'hFF)) begin
            err_cnt_q <= err_cnt_q + 8'd1;
        end else begin
            err_cnt_q <= err_cnt_q;
        end
    end

    assign err_cnt = err_cnt_q;
`else
    assign err_cnt = 8'h00;
`endif

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// Self-checking bench for ps2_rx_fifo: frames are bit-banged on the PS/2
// lines, good bytes are queued as expectations and compared when popped.
module tb_ps2_rx_fifo;

    localparam int DEPTH = 8;
    localparam int TMO   = 5000;
    localparam int HALF  = 20;      // clk cycles per PS/2 half bit
`ifdef PS2_RX_ERR_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       clrn = 1'b0;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic       nextdata_n = 1'b1;
    logic [7:0] data;
    logic       ready;
    logic [3:0] level;
    logic       overflow, parity_err, frame_err, timeout_err;
    logic [7:0] err_cnt;

    int         n_vec = 0;
    int         n_err = 0;
    logic [7:0] exp_q[$];
    bit         exp_ovf = 1'b0;
    int         exp_rej = 0;

    ps2_rx_fifo #(.FIFO_DEPTH(DEPTH), .SYNC_STAGES(2), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .clrn(clrn), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
        .nextdata_n(nextdata_n), .data(data), .ready(ready), .level(level),
        .overflow(overflow), .parity_err(parity_err), .frame_err(frame_err),
        .timeout_err(timeout_err), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    // Single comparison point for the whole bench.
    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] next_exp();
        if (exp_q.size() > 0) return {24'd0, exp_q.pop_front()};
        return 32'hDEAD;
    endfunction

    function automatic int exp_err_cnt();
        return CNT_EN ? exp_rej : 0;
    endfunction

    // Frame bits, index 0 first on the wire: start, d0..d7, parity, stop.
    function automatic logic [10:0] mk_frame(input logic [7:0] d, input bit bad_par, input bit bad_stop);
        logic par;
        par = ~(^d) ^ bad_par;
        return {(bad_stop ? 1'b0 : 1'b1), par, d, 1'b0};
    endfunction

    // Drive n frame bits. On the last falling edge the stop strobe is seen
    // after two clk edges and acted on at the third.
    task automatic send_bits(input logic [10:0] bits, input int n, input bit chk_lat, input bit pop_last);
        for (int b = 0; b < n; b++) begin
            ps2_data = bits[b];
            repeat (HALF) @(negedge clk);
            ps2_clk = 1'b0;
            for (int i = 0; i < HALF; i++) begin
                @(negedge clk);
                if (b == n - 1 && i == 1) begin
                    if (chk_lat) check_eq("rdy_before_stop", ready, 1'b0);
                    if (pop_last) begin
                        check_eq("pop_on_write_data", data, next_exp());
                        nextdata_n = 1'b0;
                    end
                end
                if (b == n - 1 && i == 2) begin
                    nextdata_n = 1'b1;
                    if (chk_lat) begin
                        check_eq("rdy_after_stop", ready, 1'b1);
                        check_eq("lat_level", level, 4'd1);
                    end
                end
            end
            ps2_clk = 1'b1;
        end
        ps2_data = 1'b1;
        repeat (HALF) @(negedge clk);
    endtask

    // Send a complete frame and update the scoreboard.
    task automatic send_frame(input logic [7:0] d, input bit bad_par, input bit bad_stop,
                              input bit chk_lat, input bit pop_last);
        if (bad_par || bad_stop) exp_rej++;
        else if (exp_q.size() < DEPTH || pop_last) exp_q.push_back(d);
        else exp_ovf = 1'b1;
        send_bits(mk_frame(d, bad_par, bad_stop), 11, chk_lat, pop_last);
    endtask

    // Pop one entry with a single-cycle nextdata_n pulse.
    task automatic pop_one(input string tag);
        check_eq({tag, "_rdy"}, ready, 1'b1);
        check_eq({tag, "_data"}, data, next_exp());
        nextdata_n = 1'b0;
        @(negedge clk);
        nextdata_n = 1'b1;
        check_eq({tag, "_level"}, level, exp_q.size());
    endtask

    task automatic check_cleared(input string tag);
        check_eq({tag, "_ready"}, ready, 1'b0);
        check_eq({tag, "_level"}, level, 4'd0);
        check_eq({tag, "_ovf"}, overflow, 1'b0);
        check_eq({tag, "_perr"}, parity_err, 1'b0);
        check_eq({tag, "_ferr"}, frame_err, 1'b0);
        check_eq({tag, "_terr"}, timeout_err, 1'b0);
        check_eq({tag, "_ecnt"}, err_cnt, 8'd0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset state
        #1;
        check_cleared("reset");
        repeat (4) @(negedge clk);
        clrn = 1'b1;
        repeat (4) @(negedge clk);

        // Single frame, ready latency, single pop
        send_frame(8'h1C, 1'b0, 1'b0, 1'b1, 1'b0);
        check_eq("f1c_level", level, 4'd1);
        pop_one("f1c_pop");
        check_eq("f1c_rdy_empty", ready, 1'b0);

        // Parity and stop-bit errors are rejected
        send_frame(8'h5A, 1'b1, 1'b0, 1'b0, 1'b0);
        send_frame(8'h5A, 1'b0, 1'b1, 1'b0, 1'b0);
        check_eq("perr", parity_err, 1'b1);
        check_eq("ferr", frame_err, 1'b1);
        check_eq("err_level", level, 4'd0);
        check_eq("err_cnt2", err_cnt, exp_err_cnt());

        // Partial frame times out, next frame decodes cleanly
        send_bits(mk_frame(8'h0F, 1'b0, 1'b0), 5, 1'b0, 1'b0);
        repeat (TMO + 2) @(negedge clk);
        exp_rej++;
        check_eq("terr", timeout_err, 1'b1);
        check_eq("terr_level", level, 4'd0);
        check_eq("err_cnt3", err_cnt, exp_err_cnt());
        send_frame(8'hF0, 1'b0, 1'b0, 1'b1, 1'b0);
        pop_one("ff0_pop");

        // Overflow: nine frames into an eight-entry FIFO
        for (int k = 1; k <= 9; k++) send_frame(k[7:0], 1'b0, 1'b0, 1'b0, 1'b0);
        check_eq("ovf_level", level, 4'd8);
        check_eq("ovf_flag", overflow, exp_ovf);
        for (int k = 0; k < 8; k++) pop_one("ovf_pop");
        check_eq("ovf_drained_rdy", ready, 1'b0);

        // Reset clears sticky flags
        clrn = 1'b0;
        #1;
        check_cleared("rst2");
        @(negedge clk);
        clrn = 1'b1;
        exp_rej = 0;
        exp_ovf = 1'b0;
        repeat (4) @(negedge clk);

        // Full FIFO with simultaneous write and pop
        for (int k = 0; k < 8; k++) send_frame(8'h10 + k[7:0], 1'b0, 1'b0, 1'b0, 1'b0);
        send_frame(8'hA5, 1'b0, 1'b0, 1'b0, 1'b1);
        check_eq("wp_level", level, 4'd8);
        check_eq("wp_ovf", overflow, 1'b0);

        // Held nextdata_n drains one entry per cycle, then stops at empty
        nextdata_n = 1'b0;
        for (int k = 0; k < 8; k++) begin
            check_eq("burst_data", data, next_exp());
            @(negedge clk);
        end
        check_eq("burst_level", level, 4'd0);
        @(negedge clk);
        check_eq("burst_empty_level", level, 4'd0);
        check_eq("burst_empty_rdy", ready, 1'b0);
        nextdata_n = 1'b1;

        // Reset mid-frame clears everything at once and drops the partial frame
        send_frame(8'h66, 1'b0, 1'b0, 1'b0, 1'b0);
        send_bits(mk_frame(8'h99, 1'b0, 1'b0), 5, 1'b0, 1'b0);
        #3;
        clrn = 1'b0;
        #1;
        check_cleared("rst_mid");
        exp_q.delete();
        @(negedge clk);
        @(negedge clk);
        clrn = 1'b1;
        repeat (4) @(negedge clk);
        send_frame(8'h3C, 1'b0, 1'b0, 1'b1, 1'b0);
        pop_one("after_rst_pop");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/ps2_rx_fifo.md
PS2_RX_FIFO -- requirements
Module: ps2_rx_fifo

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 8, scan-code FIFO entries; power of two, >= 2.
REQ-002 SHALL have parameter SYNC_STAGES, default 2, synchroniser flops on ps2_clk and ps2_data; >= 2.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 5000, clk cycles without a ps2_clk falling edge before a partial frame is aborted.
REQ-004 SHALL have port clk, input, 1, single system clock, all logic on its rising edge.
REQ-005 SHALL have port clrn, input, 1, asynchronous active-low reset.
REQ-006 SHALL have ports ps2_clk and ps2_data, input, 1 each, asynchronous PS/2 lines.
REQ-007 SHALL have port nextdata_n, input, 1, active-low pop request.
REQ-008 SHALL have port data, output, 8, head-of-FIFO scan code.
REQ-009 SHALL have port ready, output, 1, FIFO non-empty.
REQ-010 SHALL have port level, output, $clog2(FIFO_DEPTH)+1, FIFO occupancy.
REQ-011 SHALL have ports overflow, parity_err, frame_err and timeout_err, output, 1 each, sticky error flags.
REQ-012 SHALL have port err_cnt, output, 8, count of rejected frames (see Configuration).

Function
REQ-013 SHALL pass ps2_clk and ps2_data through SYNC_STAGES flops each, detecting a falling edge as synced previous=1, current=0 (one-cycle strobe).
REQ-014 SHALL use FSM IDLE/RECV; IDLE->RECV on a falling edge with synced ps2_data=0 (start bit); a falling edge with ps2_data=1 in IDLE is ignored.
REQ-015 In RECV, SHALL shift 8 data bits LSB-first, then the parity bit, then on the 11th edge (stop) evaluate and return to IDLE.
REQ-016 SHALL accept a frame only if stop=1 and parity is odd over data+parity; a parity failure sets parity_err, a stop=0 sets frame_err, and a rejected frame is not written.
REQ-017 SHALL abort to IDLE, discard bits and set timeout_err when TIMEOUT_CYCLES elapse in RECV without a falling edge; the counter reloads on every edge.
REQ-018 SHALL drive ready=1 on the cycle after the stop-bit strobe of an accepted frame into an empty FIFO.
REQ-019 SHALL present data = entry at read pointer combinationally; value undefined when ready=0.
REQ-020 SHALL pop one entry on each clk edge where ready=1 and nextdata_n=0; holding nextdata_n low pops every cycle until empty; a pop when empty is ignored.
REQ-021 SHALL, on write while full with no same-cycle pop, drop the new byte, keep the FIFO unchanged and set overflow.
REQ-022 SHALL, on write and pop in the same cycle (including full), perform both, leaving level unchanged and overflow not set.
REQ-023 SHALL wrap pointers modulo FIFO_DEPTH; level ranges 0..FIFO_DEPTH.

Reset
REQ-024 SHALL, while clrn=0, immediately force FSM=IDLE, bit count 0, pointers 0, level=0, ready=0, and overflow, parity_err, frame_err, timeout_err and err_cnt to 0; FIFO contents are not reset.
REQ-025 SHALL discard any frame in progress when reset is asserted; after release, reception restarts on the next start bit.

Configuration
REQ-026 With PS2_RX_ERR_CNT_EN defined, err_cnt SHALL increment on every parity, frame or timeout rejection and saturate at 255.
REQ-027 Without PS2_RX_ERR_CNT_EN, err_cnt SHALL be tied to 0 and no counter logic is generated; all other behaviour is unchanged.

Verification
REQ-028 Send frame 0x1C with good parity -> ready=1 one cycle after the stop strobe, data=0x1C, level=1; pulse nextdata_n one cycle -> ready=0, level=0.
REQ-029 Send 9 good frames 0x01..0x09 without popping (FIFO_DEPTH=8) -> level=8, overflow=1; pops return 0x01..0x08 in order.
REQ-030 Send 0x5A with even parity, then 0x5A with stop=0 -> parity_err=1, frame_err=1, level=0, err_cnt=2 with the macro, 0 without.
REQ-031 Send start bit + 4 bits, then idle TIMEOUT_CYCLES+2 clk -> timeout_err=1, FSM IDLE; the next good 0xF0 frame is received correctly.
REQ-032 Fill the FIFO to 8, then hold nextdata_n=0 as a new frame completes -> level stays 8, overflow=0; assert clrn mid-frame -> all outputs 0 immediately.
